pipe_skid: RTL and testbench



---
 rtl/pipe_skid.sv | 93 +++++++++
 tb/tb_pipe_skid.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid.sv
// Elastic valid/ready pipeline stage: DEPTH-entry circular buffer, registered upstream ready, sync flush.
// Optional macro PIPE_SKID_LEVEL_EN adds the `level` occupancy port and protocol assertions.
module pipe_skid #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  pin_valid,
   input  logic [DATA_WIDTH-1:0] pin_data,
   output logic                  pin_ready,
   output logic                  pout_valid,
   output logic [DATA_WIDTH-1:0] pout_data,
   input  logic                  pout_ready
`ifdef PIPE_SKID_LEVEL_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  pin_ready_q, pin_ready_d;
   logic                  push, pop;

   // Flush squashes both directions, so a concurrent payload never lands in storage.
   assign push = pin_valid & pin_ready_q & ~flush;
   assign pop  = pout_valid & pout_ready & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_d = count_q + CNT_ONE;
         else if (pop && !push) count_d = count_q - CNT_ONE;
      end
      // Ready is the next-state fullness, held in its own flop so it never sees pout_ready combinationally.
      pin_ready_d = (count_d != DEPTH_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pin_ready_q <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pin_ready_q <= pin_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= pin_data;
   end

   always_comb begin
      pin_ready  = pin_ready_q;
      pout_valid = (count_q != '0);
      pout_data  = pout_valid ? mem_q[rd_ptr_q] : '0;
   end

`ifdef PIPE_SKID_LEVEL_EN
   assign level = count_q;

   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(push && count_q == DEPTH_C));
   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count_q <= DEPTH_C);
   a_out_stable: assert property (@(posedge clk) disable iff (rst)
      (pout_valid && !pout_ready && !flush) |=> $stable(pout_data));
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Directed vector table plus hand-written sequences for pipe_skid (DEPTH=2) and a scoreboarded DEPTH=3 run.
module tb_pipe_skid;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush2 = 1'b0, pv2 = 1'b0, pr2 = 1'b0;
   logic [31:0] pd2 = '0;
   logic        rdy2, ov2;
   logic [31:0] od2;
   logic        flush3 = 1'b0, pv3 = 1'b0, pr3 = 1'b0;
   logic [31:0] pd3 = '0;
   logic        rdy3, ov3;
   logic [31:0] od3;
`ifdef PIPE_SKID_LEVEL_EN
   logic [1:0]  level2, level3;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_skid #(.DATA_WIDTH(32), .DEPTH(2)) u2 (
      .clk(clk), .rst(rst), .flush(flush2),
      .pin_valid(pv2), .pin_data(pd2), .pin_ready(rdy2),
      .pout_valid(ov2), .pout_data(od2), .pout_ready(pr2)
`ifdef PIPE_SKID_LEVEL_EN
      , .level(level2)
`endif
   );

   pipe_skid #(.DATA_WIDTH(32), .DEPTH(3)) u3 (
      .clk(clk), .rst(rst), .flush(flush3),
      .pin_valid(pv3), .pin_data(pd3), .pin_ready(rdy3),
      .pout_valid(ov3), .pout_data(od3), .pout_ready(pr3)
`ifdef PIPE_SKID_LEVEL_EN
      , .level(level3)
`endif
   );

   typedef struct {
      logic        pv;
      logic [31:0] pd;
      logic        pr;
      logic        fl;
      logic        e_rdy;
      logic        e_val;
      logic [31:0] e_dat;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(logic pv, logic [31:0] pd, logic pr, logic fl,
                               logic e_rdy, logic e_val, logic [31:0] e_dat);
      vec_t v;
      v.pv = pv; v.pd = pd; v.pr = pr; v.fl = fl;
      v.e_rdy = e_rdy; v.e_val = e_val; v.e_dat = e_dat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int          sent, rcvd, cyc;
   logic [31:0] sb[$];

   initial begin
      // Expected outputs are the state seen before the edge at which the inputs are applied.
      vecs[0]  = mk(1, 32'hA,  0, 0, 1, 0, 32'h0);
      vecs[1]  = mk(1, 32'hB,  0, 0, 1, 1, 32'hA);
      vecs[2]  = mk(1, 32'hC,  0, 0, 0, 1, 32'hA);
      vecs[3]  = mk(1, 32'hC,  1, 0, 0, 1, 32'hA);
      vecs[4]  = mk(1, 32'hC,  1, 0, 1, 1, 32'hB);
      vecs[5]  = mk(0, 32'h0,  1, 0, 1, 1, 32'hC);
      vecs[6]  = mk(0, 32'h0,  0, 0, 1, 0, 32'h0);
      vecs[7]  = mk(1, 32'h11, 0, 0, 1, 0, 32'h0);
      vecs[8]  = mk(1, 32'h77, 1, 0, 1, 1, 32'h11);
      vecs[9]  = mk(1, 32'h22, 0, 0, 1, 1, 32'h77);
      vecs[10] = mk(1, 32'h55, 0, 1, 0, 1, 32'h77);
      vecs[11] = mk(1, 32'h66, 0, 0, 1, 0, 32'h0);
      vecs[12] = mk(0, 32'h0,  1, 0, 1, 1, 32'h66);
      vecs[13] = mk(0, 32'h0,  1, 0, 1, 0, 32'h0);
      vecs[14] = mk(1, 32'h33, 0, 0, 1, 0, 32'h0);
      vecs[15] = mk(1, 32'h55, 0, 1, 1, 1, 32'h33);
      vecs[16] = mk(0, 32'h0,  1, 0, 1, 0, 32'h0);
      vecs[17] = mk(0, 32'h0,  0, 0, 1, 0, 32'h0);

      repeat (3) @(posedge clk);
      chk("reset_rdy", {31'b0, rdy2}, 32'h1);
      chk("reset_val", {31'b0, ov2}, 32'h0);
      chk("reset_dat", od2, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 18; i++) begin
         pv2 = vecs[i].pv; pd2 = vecs[i].pd; pr2 = vecs[i].pr; flush2 = vecs[i].fl;
         #1;
         chk($sformatf("vec%0d_rdy", i), {31'b0, rdy2}, {31'b0, vecs[i].e_rdy});
         chk($sformatf("vec%0d_val", i), {31'b0, ov2}, {31'b0, vecs[i].e_val});
         chk($sformatf("vec%0d_dat", i), od2, vecs[i].e_dat);
         $display("vec %0d: pv=%0b pd=0x%0h pr=%0b fl=%0b -> rdy=%0b val=%0b dat=0x%0h",
                  i, pv2, pd2, pr2, flush2, rdy2, ov2, od2);
         tick();
      end
      pv2 = 0; pr2 = 0; flush2 = 0;

      // Async reset mid-cycle with two entries held.
      pv2 = 1; pd2 = 32'hE1; tick();
      pd2 = 32'hE2; tick();
      pv2 = 0;
      chk("prerst_val", {31'b0, ov2}, 32'h1);
      chk("prerst_dat", od2, 32'hE1);
      #2 rst = 1'b1;
      #1;
      chk("asyncrst_rdy", {31'b0, rdy2}, 32'h1);
      chk("asyncrst_val", {31'b0, ov2}, 32'h0);
      chk("asyncrst_dat", od2, 32'h0);
      $display("async reset: rdy=%0b val=%0b dat=0x%0h", rdy2, ov2, od2);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Streaming at full rate: value k appears one cycle after it is pushed.
      pr2 = 1;
      for (int i = 0; i <= 16; i++) begin
         pv2 = (i < 16);
         pd2 = 32'(i + 1);
         #1;
         chk($sformatf("stream%0d_rdy", i), {31'b0, rdy2}, 32'h1);
         if (i > 0) begin
            chk($sformatf("stream%0d_val", i), {31'b0, ov2}, 32'h1);
            chk($sformatf("stream%0d_dat", i), od2, 32'(i));
         end
         $display("stream %0d: val=%0b dat=0x%0h rdy=%0b", i, ov2, od2, rdy2);
         tick();
      end
      pv2 = 0; pr2 = 0;
      #1;
      chk("stream_drained", {31'b0, ov2}, 32'h0);

      // DEPTH=3 random handshakes with a scoreboard.
      sent = 0; rcvd = 0; cyc = 0;
      pv3 = 0; pd3 = 32'h1000;
      while (rcvd < 200 && cyc < 5000) begin
         if (!pv3 && sent < 200) pv3 = ($urandom_range(0, 3) != 0);
         pr3 = ($urandom_range(0, 2) != 0);
         #1;
`ifdef PIPE_SKID_LEVEL_EN
         chk("d3_level", {30'b0, level3}, 32'(sb.size()));
`endif
         if (ov3 && pr3) begin
            if (sb.size() == 0) begin
               chk("d3_unexpected_out", od3, 32'hFFFF_FFFF);
            end else begin
               chk($sformatf("d3_out%0d", rcvd), od3, sb.pop_front());
            end
            $display("d3 pop %0d: dat=0x%0h", rcvd, od3);
            rcvd++;
         end
         if (pv3 && rdy3) begin
            sb.push_back(pd3);
            sent++;
         end
         tick();
         if (pv3 && sb.size() > 0 && sb[$] == pd3) begin
            pd3 = pd3 + 1;
            pv3 = 0;
         end
         cyc++;
      end
      pv3 = 0; pr3 = 0;
      chk("d3_received", 32'(rcvd), 32'd200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
